sync_debounce_edge: RTL

- Input-conditioning stage that sits directly upstream of the team's D flip-flop register blocks.
- Takes a raw, asynchronous, possibly bouncy level `d` and synchronises it into `clk` through a flop chain.
- Debounces it with a counter-based FSM and presents a clean level `q`.
- Also emits single-cycle `rise`/`fall` pulses, ready to drive the `d` or enable input of a downstream register.

---
 rtl/sync_debounce_edge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sync_debounce_edge.sv
// Synchroniser + counter-based debouncer with registered level and rise/fall pulses.
// Optional accepted-rising-edge counter enabled by defining EDGE_COUNT_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_LOW   | accepted level 0, d_sync idle low
// S_CHK_H | accepted level 0, counting consecutive high d_sync samples
// S_HIGH  | accepted level 1, d_sync idle high
// S_CHK_L | accepted level 1, counting consecutive low d_sync samples
module sync_debounce_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d,
  output logic             q,
  output logic             rise,
  output logic             fall
`ifdef EDGE_COUNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  typedef enum logic [1:0] {
    S_LOW   = 2'b00,
    S_CHK_H = 2'b01,
    S_HIGH  = 2'b10,
    S_CHK_L = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_sync;

  state_e                 state_q, state_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Raw d only ever enters sync[0]; everything downstream sees d_sync.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], d};
  assign d_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        level_d = 1'b0;
        if (d_sync) begin
          state_d = S_CHK_H;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_CHK_H: begin
        level_d = 1'b0;
        if (!d_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      S_HIGH: begin
        level_d = 1'b1;
        if (!d_sync) begin
          state_d = S_CHK_L;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_CHK_L: begin
        level_d = 1'b1;
        if (d_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Counts from the registered pulse, so it lags rise by one cycle and wraps freely.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (rise_q) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule
